csa_multiop_accum: RTL and testbench



---
 rtl/csa_multiop_accum.sv | 107 ++++++++++
 tb/tb_csa_multiop_accum.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/csa_multiop_accum.sv
// Burst accumulator: folds N operands into redundant sum/carry registers with a
// 3:2 carry-save step per operand, then resolves them with one carry-propagate add.
module csa_multiop_accum #(
    parameter int M     = 8,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_ops,
    input  logic                 clear,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [M-1:0]         in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [M+CNT_W-1:0]   result
);

    localparam int ACCW = M + CNT_W;

    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

    state_t            state_q, state_d;
    logic [ACCW-1:0]   s_q, s_d;
    logic [ACCW-1:0]   c_q, c_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACCW-1:0]   result_q, result_d;

    logic [ACCW-1:0]   x_ext;
    logic [ACCW-1:0]   maj;
    logic              xfer;

    assign x_ext = {{CNT_W{1'b0}}, in_data};
    assign maj   = (s_q & c_q) | (s_q & x_ext) | (c_q & x_ext);
    assign xfer  = (state_q == ACCUM) && in_valid && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = (num_ops != '0) ? ACCUM : RESOLVE;
                ACCUM:   if (in_valid && cnt_q == CNT_W'(1)) state_d = RESOLVE;
                RESOLVE: state_d = DONE;
                DONE:    if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == DONE);
    end

    // Clear flushes the partial sums but leaves the last delivered result intact.
    always_comb begin
        s_d      = s_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (clear) begin
            s_d   = '0;
            c_d   = '0;
            cnt_d = '0;
        end else if (state_q == IDLE && start) begin
            s_d   = '0;
            c_d   = '0;
            cnt_d = num_ops;
        end else if (xfer) begin
            s_d   = s_q ^ c_q ^ x_ext;
            c_d   = {maj[ACCW-2:0], 1'b0};
            cnt_d = cnt_q - CNT_W'(1);
        end else if (state_q == RESOLVE) begin
            result_d = s_q + c_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q      <= '0;
            c_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            s_q      <= s_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_csa_multiop_accum.sv
// Directed bench for csa_multiop_accum with hand-computed expected results.
module tb_csa_multiop_accum;

    localparam int M     = 8;
    localparam int CNT_W = 4;
    localparam int ACCW  = M + CNT_W;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [CNT_W-1:0]  num_ops;
    logic              clear;
    logic              busy;
    logic              in_valid;
    logic              in_ready;
    logic [M-1:0]      in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACCW-1:0]   result;

    int total = 0;
    int bad   = 0;
    int xfers = 0;
    int base;
    int accepted;
    int cycles;
    int v;

    csa_multiop_accum #(.M(M), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_ops   (num_ops),
        .clear     (clear),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent count of operand transfers, excluding cycles voided by clear.
    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready && !clear) xfers <= xfers + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic [CNT_W-1:0] n,
                                 input logic iv, input logic [M-1:0] d,
                                 input logic ordy, input logic clr);
        start     = st;
        num_ops   = n;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        clear     = clr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        #12;
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_in_ready", 32'(in_ready), 0);
        checkOutput("reset_out_valid", 32'(out_valid), 0);
        checkOutput("reset_result", 32'(result), 0);
        rst_n = 1'b1;
        tick();

        $display("[TB] basic burst 0x12+0x34+0x56");
        base = xfers;
        applyStimulus(1, 3, 0, 8'h00, 0, 0);
        tick();
        checkOutput("b1_busy", 32'(busy), 1);
        checkOutput("b1_in_ready", 32'(in_ready), 1);
        applyStimulus(0, 0, 1, 8'h12, 0, 0);
        tick();
        applyStimulus(0, 0, 1, 8'h34, 0, 0);
        tick();
        applyStimulus(0, 0, 1, 8'h56, 0, 0);
        tick();
        checkOutput("b1_resolve_in_ready", 32'(in_ready), 0);
        checkOutput("b1_resolve_out_valid", 32'(out_valid), 0);
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        tick();
        checkOutput("b1_out_valid", 32'(out_valid), 1);
        checkOutput("b1_result", 32'(result), 32'h09C);
        checkOutput("b1_xfers", 32'(xfers - base), 3);

        $display("[TB] output backpressure with start pulses");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 5, 0, 8'h00, 0, 0);
            tick();
            checkOutput("bp_out_valid", 32'(out_valid), 1);
            checkOutput("bp_result", 32'(result), 32'h09C);
            checkOutput("bp_busy", 32'(busy), 1);
        end
        applyStimulus(1, 5, 0, 8'h00, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        checkOutput("bp_release_out_valid", 32'(out_valid), 0);
        checkOutput("bp_release_busy", 32'(busy), 0);
        tick();
        checkOutput("bp_idle_busy", 32'(busy), 0);

        $display("[TB] max-value burst with random stalls");
        base = xfers;
        applyStimulus(1, 15, 0, 8'h00, 0, 0);
        tick();
        accepted = 0;
        cycles   = 0;
        while (accepted < 15 && cycles < 300) begin
            v = int'($urandom_range(0, 1));
            applyStimulus(0, 0, v[0], 8'hFF, 0, 0);
            checkOutput("max_in_ready", 32'(in_ready), 1);
            accepted += v;
            tick();
            cycles++;
        end
        checkOutput("max_within_budget", 32'(accepted), 15);
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        checkOutput("max_resolve_out_valid", 32'(out_valid), 0);
        tick();
        checkOutput("max_out_valid", 32'(out_valid), 1);
        checkOutput("max_result", 32'(result), 32'hEF1);
        checkOutput("max_xfers", 32'(xfers - base), 15);
        applyStimulus(0, 0, 0, 8'h00, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 8'h00, 0, 0);

        $display("[TB] clear after 2 of 4 operands");
        base = xfers;
        applyStimulus(1, 4, 0, 8'h00, 0, 0);
        tick();
        applyStimulus(0, 0, 1, 8'h10, 0, 0);
        tick();
        applyStimulus(0, 0, 1, 8'h20, 0, 0);
        tick();
        applyStimulus(0, 0, 1, 8'h30, 0, 1);
        checkOutput("clr_in_ready_during", 32'(in_ready), 1);
        tick();
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        checkOutput("clr_busy", 32'(busy), 0);
        checkOutput("clr_in_ready", 32'(in_ready), 0);
        checkOutput("clr_result_kept", 32'(result), 32'hEF1);
        checkOutput("clr_xfers", 32'(xfers - base), 2);
        applyStimulus(1, 3, 0, 8'h00, 0, 1);
        tick();
        checkOutput("clr_beats_start", 32'(busy), 0);
        applyStimulus(1, 2, 0, 8'h00, 0, 0);
        tick();
        applyStimulus(0, 0, 1, 8'h01, 0, 0);
        tick();
        applyStimulus(0, 0, 1, 8'h02, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        tick();
        checkOutput("clr_new_out_valid", 32'(out_valid), 1);
        checkOutput("clr_new_result", 32'(result), 3);
        applyStimulus(0, 0, 0, 8'h00, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 8'h00, 0, 0);

        $display("[TB] zero operand count");
        base = xfers;
        applyStimulus(1, 0, 1, 8'h77, 0, 0);
        tick();
        applyStimulus(0, 0, 1, 8'h77, 0, 0);
        checkOutput("zero_in_ready", 32'(in_ready), 0);
        checkOutput("zero_busy", 32'(busy), 1);
        checkOutput("zero_resolve_out_valid", 32'(out_valid), 0);
        tick();
        checkOutput("zero_out_valid", 32'(out_valid), 1);
        checkOutput("zero_result", 32'(result), 0);
        checkOutput("zero_xfers", 32'(xfers - base), 0);
        applyStimulus(0, 0, 0, 8'h00, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 8'h00, 0, 0);

        $display("[TB] start ignored while busy");
        base = xfers;
        applyStimulus(1, 2, 0, 8'h00, 0, 0);
        tick();
        applyStimulus(1, 7, 1, 8'h05, 0, 0);
        tick();
        applyStimulus(1, 7, 1, 8'h06, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        checkOutput("busy_resolve_in_ready", 32'(in_ready), 0);
        tick();
        checkOutput("busy_out_valid", 32'(out_valid), 1);
        checkOutput("busy_result", 32'(result), 11);
        checkOutput("busy_xfers", 32'(xfers - base), 2);
        applyStimulus(0, 0, 0, 8'h00, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        checkOutput("busy_back_idle", 32'(busy), 0);

        $display("[TB] asynchronous reset mid-burst");
        applyStimulus(1, 4, 0, 8'h00, 0, 0);
        tick();
        applyStimulus(0, 0, 1, 8'h44, 0, 0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", 32'(busy), 0);
        checkOutput("arst_in_ready", 32'(in_ready), 0);
        checkOutput("arst_out_valid", 32'(out_valid), 0);
        checkOutput("arst_result", 32'(result), 0);
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        #3;
        rst_n = 1'b1;
        tick();
        checkOutput("arst_idle_busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
